// File: rtl/winner_policy_pkg.sv
// winner_policy_pkg
// Shared definitions for the epsilon-greedy next-hop selector:
//   - state_t       : decision FSM encoding (IDLE, DRAW, MOD, FETCH, SCAN, DONE)
//   - LFSR_TAPS     : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   - DEFAULT_SEED  : default nonzero LFSR reset value
//   - idx_width()   : table index width for a given table depth
//   - lfsr_next()   : one step of the 16-bit Galois LFSR
package winner_policy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_MOD,
    ST_FETCH,
    ST_SCAN,
    ST_DONE
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // A depth of one still needs a one-bit address so that ports never collapse.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Right-shifting Galois form: the bit shifted out decides whether the taps are applied.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/winner_policy_gen_index_modulo.sv
// index_modulo
// Iterative subtract-reduce: reduces a random value modulo the neighbour count
// by subtracting the divisor once per cycle. Uses a start/done handshake.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset
//   start               : load dividend/divisor and begin reducing
//   dividend [IDXW+1:0] : raw random value to be reduced
//   divisor  [IDXW:0]   : neighbour count, must be nonzero when start is high
//   done                : high in the cycle the remainder is below the divisor
//   remainder [IDXW-1:0]: reduced index, valid while done is high
module index_modulo
  import winner_policy_pkg::*;
#(
  parameter int IDXW = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [IDXW+1:0] dividend,
  input  logic [IDXW:0]   divisor,
  output logic            done,
  output logic [IDXW-1:0] remainder
);

  logic            active;
  logic [IDXW+1:0] rem;
  logic [IDXW:0]   div;
  logic            ge;

  assign ge = (rem >= {1'b0, div});

  // One subtraction per cycle; the final check cycle (rem < div) is the done cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active <= 1'b0;
      rem    <= '0;
      div    <= '0;
    end else if (start) begin
      active <= 1'b1;
      rem    <= dividend;
      div    <= divisor;
    end else if (active) begin
      if (ge) begin
        rem <= rem - {1'b0, div};
      end else begin
        active <= 1'b0;
      end
    end
  end

  assign done      = active & ~ge;
  // Once below the divisor (<= MAX_NEIGHBORS) the value fits the index width.
  assign remainder = rem[IDXW-1:0];

endmodule

// File: rtl/winner_policy_gen.sv
// winner_policy_gen
// Epsilon-greedy next-hop selector for the Q-routing node. Each decision draws
// from a free-running LFSR and either explores (random neighbour) or exploits
// (highest-Q neighbour, falling back to the node's own best hop).
// Optional build macro: WINNER_POLICY_EPS_DECAY_EN
//   defined   : eps lives in a loadable register that decays by epsilon_step on
//               every done, floored at EPS_MIN (a coincident eps_load wins)
//   undefined : eps is the epsilon input sampled at start; eps_load and
//               epsilon_step are ignored
// Ports:
//   clock, reset           : clock and asynchronous active-high reset
//   start                  : request a decision (sampled only in IDLE)
//   neighbor_count [IDXW:0]: number of valid table entries, 0..MAX_NEIGHBORS
//   my_best, best_hop      : node's own best Q and its fallback next hop
//   epsilon, eps_load      : exploration probability value and its load strobe
//   epsilon_step           : decay amount per decision
//   nb_addr                : neighbour table read address
//   nb_id, nb_q            : table data, valid one cycle after nb_addr
//   next_hop, explored     : decision result, held until the next done
//   done                   : one-cycle completion pulse
//   busy                   : high whenever the FSM is not in IDLE
module winner_policy_gen
  import winner_policy_pkg::*;
#(
  parameter int          WORD_WIDTH    = 16,
  parameter int          MAX_NEIGHBORS = 8,
  parameter int          EPS_WIDTH     = 4,
  parameter logic [15:0] LFSR_SEED     = DEFAULT_SEED,
  parameter int          EPS_MIN       = 0,
  localparam int         IDXW          = idx_width(MAX_NEIGHBORS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IDXW:0]         neighbor_count,
  input  logic [WORD_WIDTH-1:0] my_best,
  input  logic [WORD_WIDTH-1:0] best_hop,
  input  logic [EPS_WIDTH:0]    epsilon,
  input  logic                  eps_load,
  input  logic [EPS_WIDTH:0]    epsilon_step,
  output logic [IDXW-1:0]       nb_addr,
  input  logic [WORD_WIDTH-1:0] nb_id,
  input  logic [WORD_WIDTH-1:0] nb_q,
  output logic [WORD_WIDTH-1:0] next_hop,
  output logic                  explored,
  output logic                  done,
  output logic                  busy
);

  localparam logic [IDXW:0]      MAX_CNT   = (IDXW + 1)'(MAX_NEIGHBORS);
  localparam logic [EPS_WIDTH:0] EPS_FLOOR = (EPS_WIDTH + 1)'(EPS_MIN);

  state_t                state, state_nxt;
  logic [15:0]           lfsr;
  logic [IDXW:0]         count_q;
  logic [IDXW:0]         scan_cnt;
  logic [IDXW:0]         scan_nxt;
  logic [WORD_WIDTH-1:0] my_best_q;
  logic [WORD_WIDTH-1:0] best_hop_q;
  logic [WORD_WIDTH-1:0] run_q;
  logic [WORD_WIDTH-1:0] run_id;
  logic [WORD_WIDTH-1:0] cand_q;
  logic [WORD_WIDTH-1:0] cand_id;
  logic [WORD_WIDTH-1:0] next_hop_q;
  logic                  explored_q;
  logic [EPS_WIDTH:0]    eps_reg;
  logic                  explore_hit;
  logic                  take_new;
  logic                  mod_start;
  logic                  mod_done;
  logic [IDXW-1:0]       mod_rem;

  // Free-running random source; it advances every cycle regardless of state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  // Zero-extending the drawn bits means any eps >= 2^EPS_WIDTH always explores.
  assign explore_hit = ({1'b0, lfsr[15 -: EPS_WIDTH]} < eps_reg);

`ifdef WINNER_POLICY_EPS_DECAY_EN
  logic [EPS_WIDTH:0] eps_dec;
  logic [EPS_WIDTH:0] eps_sat;

  assign eps_dec = (eps_reg > epsilon_step) ? (eps_reg - epsilon_step) : '0;
  assign eps_sat = (eps_dec < EPS_FLOOR) ? EPS_FLOOR : eps_dec;

  // Persistent epsilon: an explicit load takes priority over the per-decision decay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eps_reg <= '0;
    end else if (eps_load) begin
      eps_reg <= epsilon;
    end else if (state == ST_DONE) begin
      eps_reg <= eps_sat;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg = ^{eps_load, epsilon_step, EPS_FLOOR};

  // Without decay, each decision simply uses the epsilon present at its start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      eps_reg <= '0;
    end else if ((state == ST_IDLE) && start) begin
      eps_reg <= epsilon;
    end
  end
`endif

  index_modulo #(
    .IDXW (IDXW)
  ) u_index_modulo (
    .clock     (clock),
    .reset     (reset),
    .start     (mod_start),
    .dividend  (lfsr[IDXW+1:0]),
    .divisor   (count_q),
    .done      (mod_done),
    .remainder (mod_rem)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the modulo unit is kicked off from DRAW with the same r.
  always_comb begin
    state_nxt = state;
    mod_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (count_q == '0) begin
          state_nxt = ST_DONE;
        end else if (explore_hit) begin
          mod_start = 1'b1;
          state_nxt = ST_MOD;
        end else begin
          state_nxt = ST_SCAN;
        end
      end
      ST_MOD: begin
        if (mod_done) begin
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_nxt = ST_DONE;
      end
      ST_SCAN: begin
        if (scan_cnt == count_q) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // scan_cnt = number of addresses already issued; data for index scan_cnt-1 is
  // on nb_q this cycle. The first returned entry seeds the running maximum, and
  // later entries replace it only when strictly greater, so ties keep the lowest index.
  assign scan_nxt = scan_cnt + 1'b1;
  assign take_new = (scan_cnt == (IDXW + 1)'(1)) || (nb_q > run_q);
  assign cand_q   = take_new ? nb_q  : run_q;
  assign cand_id  = take_new ? nb_id : run_id;

  // Datapath registers: request latching, table address sequencing, running max
  // and the held result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      my_best_q  <= '0;
      best_hop_q <= '0;
      nb_addr    <= '0;
      scan_cnt   <= '0;
      run_q      <= '0;
      run_id     <= '0;
      next_hop_q <= '0;
      explored_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            count_q    <= (neighbor_count > MAX_CNT) ? MAX_CNT : neighbor_count;
            my_best_q  <= my_best;
            best_hop_q <= best_hop;
          end
        end
        ST_DRAW: begin
          if (count_q == '0) begin
            next_hop_q <= best_hop_q;
            explored_q <= 1'b0;
          end else if (!explore_hit) begin
            nb_addr  <= '0;
            scan_cnt <= '0;
          end
        end
        ST_MOD: begin
          if (mod_done) begin
            nb_addr <= mod_rem;
          end
        end
        ST_FETCH: begin
          explored_q <= 1'b1;
        end
        ST_SCAN: begin
          scan_cnt <= scan_nxt;
          if (scan_nxt < count_q) begin
            nb_addr <= scan_nxt[IDXW-1:0];
          end
          if (scan_cnt != '0) begin
            run_q  <= cand_q;
            run_id <= cand_id;
          end
          if (scan_cnt == count_q) begin
            next_hop_q <= (cand_q > my_best_q) ? cand_id : best_hop_q;
            explored_q <= 1'b0;
          end
        end
        ST_DONE: begin
          // The fetched ID only arrives in the done cycle, so capture it on exit.
          if (explored_q) begin
            next_hop_q <= nb_id;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // On an explore the fetched ID is forwarded straight through during done so the
  // result appears together with the pulse; otherwise the held register is shown.
  assign next_hop = ((state == ST_DONE) && explored_q) ? nb_id : next_hop_q;
  assign explored = explored_q;
  assign done     = (state == ST_DONE);
  assign busy     = (state != ST_IDLE);

endmodule

// File: doc/winner_policy_gen.md
# winner_policy_gen

- **Function:** parametrised epsilon-greedy next-hop selector for the Q-routing node.
- **Per decision:** on `start` it draws from an internal LFSR and either explores or exploits.
  - Explore: picks a uniformly reduced random neighbour.
  - Exploit: scans the neighbour Q table for the best entry.
- **Placement:** sits between the neighbour-table memory and the packet forwarding logic.
- **Successor features:** generalises neighbour count and widths, and adds optional on-chip epsilon decay.

## Interface
- `WORD_WIDTH`, 16, width of IDs and Q values
- `MAX_NEIGHBORS`, 8, table depth (power of two, ≥2); `IDXW = $clog2(MAX_NEIGHBORS)`
- `EPS_WIDTH`, 4, epsilon resolution; probability = eps / 2^EPS_WIDTH
- `LFSR_SEED`, 16'hACE1, LFSR reset value (nonzero)
- `EPS_MIN`, 0, decay floor
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  request decision; sampled only in IDLE
- `neighbor_count`  in  IDXW+1  valid entries, 0..MAX_NEIGHBORS
- `my_best`  in  WORD_WIDTH  node's own best Q
- `best_hop`  in  WORD_WIDTH  fallback/own-best next hop
- `epsilon`  in  EPS_WIDTH+1  value for eps_load / per-start use
- `eps_load`  in  1  load epsilon register
- `epsilon_step`  in  EPS_WIDTH+1  decay amount per decision
- `nb_addr`  out  IDXW  table read address
- `nb_id`, `nb_q`  in  WORD_WIDTH each  table data, valid one cycle after `nb_addr`
- `next_hop`  out  WORD_WIDTH  result, held until next done
- `explored`  out  1  1 = result came from exploration
- `done`  out  1  one-cycle pulse
- `busy`  out  1  high outside IDLE

## Operation
- **LFSR:** 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every cycle. Reset to `LFSR_SEED`.
- **IDLE:** on `start` latch `neighbor_count`, `my_best` and `best_hop` → DRAW. `start` is ignored while `busy`.
- **DRAW:** sample `r = lfsr`.
  - count==0 → DONE with `next_hop=best_hop`, `explored=0`.
  - Else `r[15 -: EPS_WIDTH] < eps` → MOD (explore).
  - Else → SCAN (exploit).
  - Any eps ≥ 2^EPS_WIDTH always explores. eps=0 never explores.
- **MOD:** `rem = r[IDXW+1:0]`. Each cycle, `rem ≥ count` → `rem -= count`; otherwise → FETCH.
- **FETCH:** drive `nb_addr=rem` for 1 cycle, then DONE with `next_hop=nb_id`, `explored=1`.
- **SCAN:** drive `nb_addr = 0..count-1` on consecutive cycles. Compare returned `nb_q` (unsigned) strictly greater than the running max.
  - Ties resolve to the lowest index.
  - After the last compare: max > `my_best` → `next_hop` = that `nb_id`; else `next_hop=best_hop`. `explored=0`.
- **DONE:** `done=1` for one cycle → IDLE. `next_hop` and `explored` update in the same cycle and hold afterwards.
- **Reset mid-operation:** immediate return to IDLE. Table lookups are abandoned and no done is issued.
- **Reset values:** `next_hop=0`, `explored=0`, `done=0`, `busy=0`, `nb_addr=0`, eps register=0.

## Timing
- Start edge at cycle k. `busy` is high from k+1 until the cycle after done.
- **Exploit:** `done` at k+count+3.
- **Explore:** `done` at k+4+q, where q = floor(rem0/count). Worst case q = 4·MAX_NEIGHBORS−1.
- **count==0:** `done` at k+2.
- **Back-to-back:** `start` held high restarts on the first IDLE cycle after done. Minimum gap is 1 cycle.

## Configuration
- `WINNER_POLICY_EPS_DECAY_EN` defined:
  - `eps_load` writes `epsilon` into the eps register, and every decision uses the register.
  - On each done, eps ← max(eps − `epsilon_step`, `EPS_MIN`), saturating with no underflow.
  - `eps_load` coincident with done: the load wins.
- Undefined:
  - eps = `epsilon` sampled at start.
  - `eps_load` and `epsilon_step` are ignored; the ports remain.

## Structure
- **Package `winner_policy_pkg`:** state encoding (IDLE, DRAW, MOD, FETCH, SCAN, DONE), LFSR tap constant, default seed, IDXW helper.
- **Sub-module `index_modulo`:** iterative subtract-reduce with `start`/`done`, mirroring the existing rngAddress handshake. The top FSM owns the table scan.

## Test plan
- eps_load eps=0, count=4, Q={3,9,9,2}, IDs={10,11,12,13}, my_best=5 → `next_hop=11`, `explored=0`, `done` at k+7.
- Same table, my_best=9 → `next_hop=best_hop` (50), `explored=0`.
- eps=16 (always explore), count=3, 200 decisions:
  - `explored=1` on every decision.
  - Every `next_hop` ∈ IDs.
  - Each ID is hit at least 40 times.
  - Latency matches k+4+q from the logged r.
- count=0 with start → `next_hop=best_hop`, `done` at k+2.
- `WINNER_POLICY_EPS_DECAY_EN` on: load eps=5, step=2, EPS_MIN=0 → register reads 3, 1, 0, 0 after successive dones. eps_load=7 on a done cycle → 7.
- Reset asserted during SCAN at cycle 3:
  - All outputs return to their reset values.
  - No `done` is issued.
  - A fresh start completes normally.
- start pulsed while busy → ignored, with a single done.
